store_unit: RTL and testbench
=============================

// Module: store_unit
// PURPOSE
// - Store-side data path between core and data memory: takes sb/sh/sw (sd when DWIDTH=64), aligns data to byte lanes, generates byte enables.
// - Drives a req/gnt + rvalid memory port; splits word-crossing (misaligned) stores into two beats when enabled.
// - Sits beside the load path in the MEM stage; one store in flight at a time.
// PARAMETERS
// - DWIDTH          32  data/bus width; 32 or 64 only (elaboration assert otherwise)
// - AWIDTH          32  byte-address width
// - MISALIGN_SPLIT  1   1: crossing store split into two beats; 0: crossing store -> st_err, no memory access
// PORTS
// - clk          in   1         clock, all state on rising edge
// - rst_n        in   1         asynchronous active-low reset
// - st_valid     in   1         core presents a store
// - st_ready     out  1         unit idle, can accept; transfer when st_valid&&st_ready
// - instr        in   instr_t   store instruction; instr.S.funct3 selects size
// - st_addr      in   AWIDTH    byte address
// - st_data      in   DWIDTH    store data, LSB-justified
// - st_done      out  1         1-cycle pulse: store complete
// - st_err       out  1         qualifies st_done: illegal funct3, rejected misalign, or mem error
// - mem_req      out  1         memory request
// - mem_gnt      in   1         request accepted this cycle
// - mem_addr     out  AWIDTH    bus-aligned address (low log2(DWIDTH/8) bits zero)
// - mem_we       out  1         constant 1 while mem_req
// - mem_be       out  DWIDTH/8  byte enables
// - mem_wdata    out  DWIDTH    lane-aligned write data
// - mem_rvalid   in   1         write response
// - mem_err      in   1         response error, valid with mem_rvalid
// BEHAVIOUR
// - Reset (async): state IDLE; st_ready=1; st_done=0; st_err=0; mem_req=0; mem_addr/mem_be/mem_wdata=0.
// - Accept in IDLE only; capture funct3, addr, data. st_ready=0 in every other state.
// - Size: funct3 0->1B, 1->2B, 2->4B, 3->8B (DWIDTH=64 only); others illegal -> st_done+st_err next cycle, no access.
// - Align: off=addr[log2(DWIDTH/8)-1:0]; ext_data={DWIDTH'0,data}<<(8*off); ext_be={0,size_mask}<<off (2x width).
//   Lo beat: addr aligned down, ext low halves. Hi beat needed iff ext_be upper half !=0: addr+DWIDTH/8, upper halves.
// - Hi needed and MISALIGN_SPLIT=0 -> st_done+st_err next cycle, no access.
// - Upper data bits beyond size are don't-care on input; lanes with be=0 drive 0.
// - FSM: IDLE -> LO_REQ (accept) -> LO_RSP (mem_gnt) -> HI_REQ (rvalid&&!err&&hi) | DONE (rvalid, no hi or err)
//   HI_REQ -> HI_RSP (mem_gnt) -> DONE (rvalid); DONE -> IDLE with st_done pulse; ERR path uses DONE.
// - mem_req=1 exactly in LO_REQ/HI_REQ; addr/be/wdata held stable until mem_gnt; no request withdrawal.
// - mem_rvalid outside *_RSP ignored; rvalid in same cycle as gnt not allowed (protocol: response >=1 cycle later).
// - Lo-beat mem_err: abort, hi beat never issued, st_done+st_err.
// - st_done/st_err registered, asserted in DONE; st_ready returns 1 the cycle after DONE.
// - Latency, aligned, gnt immediate, rvalid 1 cycle after gnt: accept c0, req c1, rvalid c2, st_done c3.
// - Reset mid-operation: FSM to IDLE, mem_req drops asynchronously, no st_done for aborted store.
// STRUCTURE
// - typedefs_pkg: store_size_e {SZ_B,SZ_H,SZ_W,SZ_D}, store_state_e {IDLE,LO_REQ,LO_RSP,HI_REQ,HI_RSP,DONE}, funct3 constants F3_SB/SH/SW/SD.
// - Sub-module store_aligner (combinational): funct3+offset+data -> lo/hi be, lo/hi wdata, need_hi, illegal.
// - store_unit: FSM, capture registers, memory port muxing.
// TESTING
// - sw 0xDEADBEEF @0x100, gnt immediate -> one beat addr 0x100 be 4'b1111 wdata 0xDEADBEEF; st_done, st_err=0.
// - sb 0x...A5 @0x103 -> addr 0x100 be 4'b1000 wdata 0xA5000000; sh 0x1234 @0x102 -> be 4'b1100 wdata 0x12340000.
// - sw 0x11223344 @0x101, SPLIT=1 -> beat1 0x100 be 1110 wdata 0x22334400; beat2 0x104 be 0001 wdata 0x00000011; one st_done.
// - same store with SPLIT=0 -> no mem_req, st_done+st_err; funct3=7 -> same.
// - gnt stalled 3 cycles -> mem_req/addr/be/wdata stable throughout; lo-beat mem_err on split store -> no hi beat, st_err=1.
// - rst_n low during LO_RSP -> mem_req 0 immediately, no st_done; next store after reset completes normally.

Source files
------------

// File: rtl/store_unit_pkg.sv
// Shared types for the store path: sizes, FSM states, funct3 codes
// and the S-type instruction view used by store_unit.
package store_unit_pkg;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W,
    SZ_D
  } store_size_e;

  typedef enum logic [2:0] {
    IDLE,
    LO_REQ,
    LO_RSP,
    HI_REQ,
    HI_RSP,
    DONE
  } store_state_e;

  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;
  localparam logic [2:0] F3_SD = 3'd3;

  typedef struct packed {
    logic [6:0] imm_hi;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] imm_lo;
    logic [6:0] opcode;
  } s_type_t;

  typedef union packed {
    logic [31:0] raw;
    s_type_t     S;
  } instr_t;

  function automatic logic [7:0] size_mask(
    input store_size_e sz
  );
    case (sz)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/store_unit_aligner.sv
// Combinational lane aligner: places store bytes on a double-width
// lane window, then splits it into the lo and hi bus beats.
module store_aligner
  import store_unit_pkg::*;
#(
  parameter int DWIDTH = 32,
  localparam int NB = DWIDTH / 8,
  localparam int OW = $clog2(NB)
) (
  input  logic [2:0]        i_funct3,
  input  logic [OW-1:0]     i_off,
  input  logic [DWIDTH-1:0] i_data,
  output logic [NB-1:0]     o_lo_be,
  output logic [NB-1:0]     o_hi_be,
  output logic [DWIDTH-1:0] o_lo_wdata,
  output logic [DWIDTH-1:0] o_hi_wdata,
  output logic              o_need_hi,
  output logic              o_illegal
);

  logic [NB-1:0]       w_mask;
  logic [2*NB-1:0]     w_ext_be;
  logic [2*DWIDTH-1:0] w_ext_data;

  always_comb begin
    w_mask    = '0;
    o_illegal = 1'b0;
    case (i_funct3)
      F3_SB: w_mask = NB'(size_mask(SZ_B));
      F3_SH: w_mask = NB'(size_mask(SZ_H));
      F3_SW: w_mask = NB'(size_mask(SZ_W));
      F3_SD: begin
        if (DWIDTH == 64) w_mask = NB'(size_mask(SZ_D));
        else              o_illegal = 1'b1;
      end
      default: o_illegal = 1'b1;
    endcase

    w_ext_be   = {{NB{1'b0}}, w_mask} << i_off;
    w_ext_data = {{DWIDTH{1'b0}}, i_data} << {i_off, 3'b000};
    // Bytes beyond the store size are don't-care; drive them as 0.
    for (int b = 0; b < 2*NB; b++) begin
      if (!w_ext_be[b]) w_ext_data[8*b +: 8] = 8'h00;
    end

    o_lo_be    = w_ext_be[NB-1:0];
    o_hi_be    = w_ext_be[2*NB-1:NB];
    o_lo_wdata = w_ext_data[DWIDTH-1:0];
    o_hi_wdata = w_ext_data[2*DWIDTH-1:DWIDTH];
    o_need_hi  = |o_hi_be;
  end

endmodule

// File: rtl/store_unit.sv
// MEM-stage store unit: accepts one store, aligns it, and drives up to
// two req/gnt + rvalid beats to data memory before pulsing st_done.
module store_unit
  import store_unit_pkg::*;
#(
  parameter int DWIDTH         = 32,
  parameter int AWIDTH         = 32,
  parameter bit MISALIGN_SPLIT = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                st_valid,
  output logic                st_ready,
  input  instr_t              instr,
  input  logic [AWIDTH-1:0]   st_addr,
  input  logic [DWIDTH-1:0]   st_data,
  output logic                st_done,
  output logic                st_err,
  output logic                mem_req,
  input  logic                mem_gnt,
  output logic [AWIDTH-1:0]   mem_addr,
  output logic                mem_we,
  output logic [DWIDTH/8-1:0] mem_be,
  output logic [DWIDTH-1:0]   mem_wdata,
  input  logic                mem_rvalid,
  input  logic                mem_err
);

  localparam int NB = DWIDTH / 8;
  localparam int OW = $clog2(NB);

  if (DWIDTH != 32 && DWIDTH != 64) begin : g_bad_dwidth
    $error("store_unit: DWIDTH must be 32 or 64");
  end

  store_state_e      r_state;
  logic              r_ready;
  logic              r_done;
  logic              r_err;
  logic              r_req;
  logic [AWIDTH-1:0] r_addr;
  logic [NB-1:0]     r_be;
  logic [DWIDTH-1:0] r_wdata;
  logic [NB-1:0]     r_hi_be;
  logic [DWIDTH-1:0] r_hi_wdata;
  logic              r_need_hi;

  logic [NB-1:0]     w_lo_be;
  logic [NB-1:0]     w_hi_be;
  logic [DWIDTH-1:0] w_lo_wdata;
  logic [DWIDTH-1:0] w_hi_wdata;
  logic              w_need_hi;
  logic              w_illegal;
  logic              w_reject;
  logic [AWIDTH-1:0] w_base;
  logic              w_unused;

  store_aligner #(.DWIDTH(DWIDTH)) u_align (
    .i_funct3   (instr.S.funct3),
    .i_off      (st_addr[OW-1:0]),
    .i_data     (st_data),
    .o_lo_be    (w_lo_be),
    .o_hi_be    (w_hi_be),
    .o_lo_wdata (w_lo_wdata),
    .o_hi_wdata (w_hi_wdata),
    .o_need_hi  (w_need_hi),
    .o_illegal  (w_illegal)
  );

  assign w_unused = ^{instr.S.imm_hi, instr.S.rs2, instr.S.rs1,
                      instr.S.imm_lo, instr.S.opcode};
  assign w_base   = {st_addr[AWIDTH-1:OW], {OW{1'b0}}};
  assign w_reject = w_illegal || (w_need_hi && !MISALIGN_SPLIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ready    <= 1'b1;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_req      <= 1'b0;
      r_addr     <= '0;
      r_be       <= '0;
      r_wdata    <= '0;
      r_hi_be    <= '0;
      r_hi_wdata <= '0;
      r_need_hi  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (st_valid) begin
            r_ready <= 1'b0;
            if (w_reject) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_err   <= 1'b1;
            end else begin
              r_state    <= LO_REQ;
              r_req      <= 1'b1;
              r_addr     <= w_base;
              r_be       <= w_lo_be;
              r_wdata    <= w_lo_wdata;
              r_hi_be    <= w_hi_be;
              r_hi_wdata <= w_hi_wdata;
              r_need_hi  <= w_need_hi;
            end
          end
        end
        LO_REQ: begin
          if (mem_gnt) begin
            r_req   <= 1'b0;
            r_state <= LO_RSP;
          end
        end
        LO_RSP: begin
          if (mem_rvalid) begin
            // A failed lo beat aborts the store; the hi beat never goes out.
            if (!mem_err && r_need_hi) begin
              r_state <= HI_REQ;
              r_req   <= 1'b1;
              r_addr  <= r_addr + AWIDTH'(NB);
              r_be    <= r_hi_be;
              r_wdata <= r_hi_wdata;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_err   <= mem_err;
            end
          end
        end
        HI_REQ: begin
          if (mem_gnt) begin
            r_req   <= 1'b0;
            r_state <= HI_RSP;
          end
        end
        HI_RSP: begin
          if (mem_rvalid) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_err   <= mem_err;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  assign st_ready  = r_ready;
  assign st_done   = r_done;
  assign st_err    = r_err;
  assign mem_req   = r_req;
  assign mem_we    = r_req;
  assign mem_addr  = r_addr;
  assign mem_be    = r_be;
  assign mem_wdata = r_wdata;

endmodule

// File: tb/tb_store_unit.sv
// Scoreboard bench for store_unit: byte-level reference model, random
// memory responder, and a monitor that checks beats and completions.
module tb_store_unit;
  import store_unit_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        st_valid = 1'b0;
  logic        ns_valid = 1'b0;
  instr_t      instr = '0;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic        st_ready, st_done, st_err;
  logic        mem_req, mem_we;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic        mem_err = 1'b0;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;

  logic        ns_ready, ns_done, ns_err, ns_req, ns_we;
  logic [31:0] ns_addr, ns_wdata;
  logic [3:0]  ns_be;

  store_unit #(.DWIDTH(32), .AWIDTH(32), .MISALIGN_SPLIT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .instr(instr), .st_addr(st_addr), .st_data(st_data),
    .st_done(st_done), .st_err(st_err), .mem_req(mem_req),
    .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid),
    .mem_err(mem_err)
  );

  store_unit #(.DWIDTH(32), .AWIDTH(32), .MISALIGN_SPLIT(1'b0)) u_ns (
    .clk(clk), .rst_n(rst_n), .st_valid(ns_valid), .st_ready(ns_ready),
    .instr(instr), .st_addr(st_addr), .st_data(st_data),
    .st_done(ns_done), .st_err(ns_err), .mem_req(ns_req),
    .mem_gnt(1'b0), .mem_addr(ns_addr), .mem_we(ns_we),
    .mem_be(ns_be), .mem_wdata(ns_wdata), .mem_rvalid(1'b0),
    .mem_err(1'b0)
  );

  typedef struct {
    logic [31:0] a;
    logic [3:0]  be;
    logic [31:0] wd;
  } beat_t;

  beat_t expq[$];
  bit    doneq[$];
  bit    rspq[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int iss_cyc, done_cyc, rdy_cyc;

  bit rand_mode = 1'b0;
  int force_stall = 0;
  int rsp_delay = 0;
  bit pend = 1'b0;
  bit pend_err = 1'b0;
  bit seen_req = 1'b0;
  int cnt = 0;
  int stall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic finish_up();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  endtask

  // Reference: walk each stored byte to its bus word and lane.
  task automatic model(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, output bit ill,
                       output bit two, output logic [31:0] a0,
                       output logic [31:0] a1, output logic [3:0] b0,
                       output logic [3:0] b1, output logic [31:0] w0,
                       output logic [31:0] w1);
    int nb;
    int pos;
    ill = (f3 > 3'd2);
    a0  = a & 32'hFFFF_FFFC;
    a1  = a0 + 32'd4;
    b0  = '0;
    b1  = '0;
    w0  = '0;
    w1  = '0;
    nb  = ill ? 0 : (1 << f3);
    for (int i = 0; i < nb; i++) begin
      pos = int'(a[1:0]) + i;
      if (pos < 4) begin
        b0[pos] = 1'b1;
        w0[8*pos +: 8] = d[8*i +: 8];
      end else begin
        b1[pos-4] = 1'b1;
        w1[8*(pos-4) +: 8] = d[8*i +: 8];
      end
    end
    two = (b1 != 4'b0000);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!st_ready) begin
      @(negedge clk);
      n++;
      if (n > 60) begin
        tests++;
        fails++;
        $display("FAIL ready_timeout: st_ready=%b required 1", st_ready);
        finish_up();
      end
    end
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d, input bit le,
                       input bit he, input bit wait_end);
    bit ill, two;
    logic [31:0] a0, a1, w0, w1;
    logic [3:0] b0, b1;
    beat_t e;
    model(f3, a, d, ill, two, a0, a1, b0, b1, w0, w1);
    wait_ready();
    instr.raw       = $urandom;
    instr.S.funct3  = f3;
    instr.S.opcode  = 7'b0100011;
    st_addr  = a;
    st_data  = d;
    st_valid = 1'b1;
    iss_cyc  = cyc;
    if (ill) begin
      doneq.push_back(1'b1);
    end else begin
      e.a = a0; e.be = b0; e.wd = w0;
      expq.push_back(e);
      rspq.push_back(le);
      if (two && !le) begin
        e.a = a1; e.be = b1; e.wd = w1;
        expq.push_back(e);
        rspq.push_back(he);
      end
      doneq.push_back(le || (two && he));
    end
    @(negedge clk);
    st_valid = 1'b0;
    if (wait_end) begin
      wait_ready();
      rdy_cyc = cyc;
    end
  endtask

  task automatic ns_try(input logic [2:0] f3, input logic [31:0] a);
    instr.raw      = $urandom;
    instr.S.funct3 = f3;
    st_addr  = a;
    st_data  = $urandom;
    ns_valid = 1'b1;
    @(negedge clk);
    ns_valid = 1'b0;
    chk("ns_done", ns_done, 1);
    chk("ns_err", ns_err, 1);
    @(negedge clk);
    chk("ns_done_pulse", ns_done, 0);
    chk("ns_ready", ns_ready, 1);
  endtask

  // Memory responder: optional grant stall, response >=1 cycle later.
  initial begin
    forever begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      mem_err    = 1'b0;
      mem_gnt    = 1'b0;
      if (pend) begin
        if (cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_err    = pend_err;
          pend       = 1'b0;
        end else begin
          cnt--;
        end
      end
      if (rst_n && mem_req && !pend && !mem_rvalid) begin
        if (!seen_req) begin
          seen_req = 1'b1;
          stall = rand_mode ? int'($urandom_range(0, 2)) : force_stall;
        end
        if (stall == 0) begin
          mem_gnt  = 1'b1;
          seen_req = 1'b0;
          pend     = 1'b1;
          pend_err = (rspq.size() > 0) ? rspq.pop_front() : 1'b0;
          cnt = rand_mode ? int'($urandom_range(0, 2)) : rsp_delay;
        end else begin
          stall--;
        end
      end
    end
  end

  // Monitor: beats on handshake, completions on st_done.
  initial begin
    bit prev_wait;
    logic [31:0] pa, pw;
    logic [3:0] pb;
    beat_t e;
    prev_wait = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (rst_n) begin
        if (mem_req && prev_wait) begin
          chk("hold_addr", mem_addr, pa);
          chk("hold_be", mem_be, pb);
          chk("hold_wdata", mem_wdata, pw);
        end
        if (mem_req && mem_gnt) begin
          if (expq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL beat: got request addr %h, required none", mem_addr);
          end else begin
            e = expq.pop_front();
            chk("beat_addr", mem_addr, e.a);
            chk("beat_be", mem_be, e.be);
            chk("beat_wdata", mem_wdata, e.wd);
            chk("beat_we", mem_we, 1);
          end
        end
        prev_wait = mem_req && !mem_gnt;
        pa = mem_addr;
        pb = mem_be;
        pw = mem_wdata;
        if (st_done) begin
          done_cyc = cyc;
          if (doneq.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL done: got st_done=1, required 0");
          end else begin
            chk("done_err", st_err, doneq.pop_front());
          end
        end
        if (ns_req) begin
          tests++;
          fails++;
          $display("FAIL ns_req: got 1 required 0");
        end
      end else begin
        prev_wait = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    tests++;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    finish_up();
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] d;
    repeat (3) @(negedge clk);
    chk("rst_ready", st_ready, 1);
    chk("rst_done", st_done, 0);
    chk("rst_err", st_err, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_be", mem_be, 0);
    chk("rst_wdata", mem_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue(F3_SW, 32'h100, 32'hDEADBEEF, 0, 0, 1);
    chk("latency", done_cyc - iss_cyc, 3);
    chk("ready_after_done", rdy_cyc - done_cyc, 1);
    d = {24'($urandom), 8'hA5};
    issue(F3_SB, 32'h103, d, 0, 0, 1);
    d = {16'($urandom), 16'h1234};
    issue(F3_SH, 32'h102, d, 0, 0, 1);
    issue(F3_SW, 32'h101, 32'h11223344, 0, 0, 1);
    issue(3'd7, 32'h100, $urandom, 0, 0, 1);
    issue(F3_SD, 32'h100, $urandom, 0, 0, 1);
    force_stall = 3;
    issue(F3_SW, 32'h200, $urandom, 0, 0, 1);
    force_stall = 0;
    issue(F3_SW, 32'h101, $urandom, 1, 0, 1);
    issue(F3_SH, 32'h103, $urandom, 0, 1, 1);

    ns_try(F3_SW, 32'h101);
    ns_try(3'd7, 32'h100);
    ns_try(F3_SH, 32'h103);

    for (int k = 0; k < 2; k++) begin
      force_stall = (k == 1) ? 6 : 0;
      rsp_delay   = (k == 1) ? 0 : 6;
      issue(F3_SW, 32'h300, $urandom, 0, 0, 0);
      @(negedge clk);
      chk("pre_rst_req", mem_req, (k == 1) ? 1 : 0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_req", mem_req, 0);
      chk("async_rst_ready", st_ready, 1);
      expq.delete();
      doneq.delete();
      rspq.delete();
      pend       = 1'b0;
      seen_req   = 1'b0;
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      @(negedge clk);
      #2 rst_n = 1'b1;
      repeat (8) @(negedge clk);
      chk("post_rst_idle", st_ready, 1);
    end
    force_stall = 0;
    rsp_delay   = 0;
    issue(F3_SW, 32'h400, $urandom, 0, 0, 1);
    chk("post_rst_latency", done_cyc - iss_cyc, 3);

    rand_mode = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(3, 7));
      else                           f3 = 3'($urandom_range(0, 2));
      issue(f3, $urandom, $urandom, $urandom_range(0, 9) == 0,
            $urandom_range(0, 9) == 0, 1);
    end

    repeat (10) @(negedge clk);
    chk("beats_left", expq.size(), 0);
    chk("dones_left", doneq.size(), 0);
    finish_up();
  end

endmodule
